div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 28 ++
 rtl/div_ctrl.sv | 158 +++++++++++++++
 tb/tb_div_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared state encodings, divide opcodes and defaults for the
//               EX-stage divider controller.
// Revision    : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    localparam logic [1:0] C_DIV_OP_NONE = 2'b00;
    localparam logic [1:0] C_DIV_OP_DIV  = 2'b01;
    localparam logic [1:0] C_DIV_OP_DIVU = 2'b10;

    localparam int C_TIMEOUT_DEFAULT = 64;

    // Opcode 2'b11 is reserved and behaves like "no divide".
    function automatic logic is_div_op(input logic [1:0] op);
        return (op == C_DIV_OP_DIV) || (op == C_DIV_OP_DIVU);
    endfunction

endpackage : div_ctrl_pkg
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Sequences a multi-cycle divide from EX: latches operands,
//               holds the pipeline, captures {quotient,remainder} into LO/HI
//               and handles flush, divide-by-zero and divider timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = C_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  div_op_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic        ex_stall_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        signed_div_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        div0_o,
    output logic        timeout_o
);

    localparam int                 C_CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYC - 1);

    div_state_t         r_state;
    logic [31:0]        r_op1;
    logic [31:0]        r_op2;
    logic               r_signed;
    logic               r_div0;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_timeout;
    logic               r_annul_pend;

    div_state_t w_state_nxt;
    logic       w_issue;
    logic       w_capture;
    logic       w_timeout_hit;
    logic       w_annul_flush;
    logic       w_start;
    logic       w_stallreq;
    logic       w_whilo;

    // Flush outranks both a divider result and a new issue in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        w_annul_flush = 1'b0;
        w_start       = 1'b0;
        w_stallreq    = 1'b0;
        w_whilo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (is_div_op(div_op_i) && !flush_i) begin
                    w_issue     = 1'b1;
                    w_stallreq  = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stallreq = 1'b1;
                if (flush_i) begin
                    w_annul_flush = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_start = 1'b1;
                    if (div_ready_i) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_timeout_hit = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_whilo = 1'b1;
                    if (!ex_stall_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op1        <= 32'd0;
            r_op2        <= 32'd0;
            r_signed     <= 1'b0;
            r_div0       <= 1'b0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_annul_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            // Timeout annul lands in the IDLE cycle after the last WAIT cycle,
            // so it can never coincide with div_start_o.
            r_annul_pend <= w_timeout_hit;
            if (w_issue) begin
                r_op1    <= reg1_i;
                r_op2    <= reg2_i;
                r_signed <= (div_op_i == C_DIV_OP_DIV);
                r_div0   <= (reg2_i == 32'd0);
                r_cnt    <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
            if (w_capture) begin
                r_lo <= r_div0 ? 32'd0 : div_result_i[63:32];
                r_hi <= r_div0 ? 32'd0 : div_result_i[31:0];
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign div_start_o   = w_start;
    assign div_annul_o   = w_annul_flush | r_annul_pend;
    assign signed_div_o  = r_signed;
    assign div_opdata1_o = r_op1;
    assign div_opdata2_o = r_op2;
    assign stallreq_o    = w_stallreq;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign whilo_o       = w_whilo;
    assign div0_o        = w_whilo & r_div0;
    assign timeout_o     = r_timeout;

endmodule : div_ctrl
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Scoreboard bench for div_ctrl with a behavioural divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  div_op_i = 2'b00;
    logic [31:0] reg1_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        ex_stall_i = 1'b0;
    logic [63:0] div_result_i = 64'd0;
    logic        div_ready_i = 1'b0;
    logic        div_start_o, div_annul_o, signed_div_o;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        stallreq_o;
    logic [31:0] hi_o, lo_o;
    logic        whilo_o, div0_o, timeout_o;

    always #5 clk = ~clk;

    div_ctrl #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .div_op_i(div_op_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .flush_i(flush_i), .ex_stall_i(ex_stall_i), .div_result_i(div_result_i),
        .div_ready_i(div_ready_i), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .signed_div_o(signed_div_o), .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o), .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .div0_o(div0_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    exp_t sb_q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   div_lat = 1;
    bit   div_respond = 1'b1;
    int   dcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference divide: truncating quotient, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = a;
            sb = b;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Behavioural divider: answers after div_lat start cycles; noisy otherwise.
    always @(posedge clk) begin
        #2;
        if (!rst && div_start_o) begin
            dcnt++;
            if (div_respond && dcnt >= div_lat) begin
                div_ready_i  = 1'b1;
                div_result_i = (div_opdata2_o == 32'd0) ? {$urandom, $urandom}
                             : ref_div(signed_div_o, div_opdata1_o, div_opdata2_o);
            end else begin
                div_ready_i  = 1'b0;
                div_result_i = {$urandom, $urandom};
            end
        end else begin
            dcnt         = 0;
            div_ready_i  = ($urandom_range(0, 1) == 1);
            div_result_i = {$urandom, $urandom};
        end
    end

    // Monitor: compare every whilo cycle against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (div_start_o || div_annul_o)
                chk("start_annul_excl", 64'(div_start_o & div_annul_o), 64'd0);
            if (whilo_o) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_whilo", 64'd1, 64'd0);
                end else begin
                    chk("hi", 64'(hi_o), 64'(sb_q[0].hi));
                    chk("lo", 64'(lo_o), 64'(sb_q[0].lo));
                    chk("div0", 64'(div0_o), 64'(sb_q[0].div0));
                    if (!ex_stall_i) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        if (b == 32'd0) begin
            e.hi = 32'd0; e.lo = 32'd0; e.div0 = 1'b1;
        end else begin
            r = ref_div(op == C_DIV_OP_DIV, a, b);
            e.lo = r[63:32]; e.hi = r[31:0]; e.div0 = 1'b0;
        end
        sb_q.push_back(e);
    endtask

    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int hold);
        int n;
        int nw;
        bit got;
        div_lat = lat;
        div_respond = 1'b1;
        push_exp(op, a, b);
        div_op_i = op; reg1_i = a; reg2_i = b; ex_stall_i = (hold > 0);
        @(negedge clk);
        chk("issue_stallreq", 64'(stallreq_o), 64'd1);
        tick();
        div_op_i = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        reg1_i = $urandom; reg2_i = $urandom;
        got = 1'b0;
        for (n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (whilo_o) begin
                got = 1'b1;
                break;
            end
            if (div_start_o) begin
                chk("signed_div", 64'(signed_div_o), 64'(op == C_DIV_OP_DIV));
                chk("opdata1", 64'(div_opdata1_o), 64'(a));
                chk("opdata2", 64'(div_opdata2_o), 64'(b));
                chk("wait_stallreq", 64'(stallreq_o), 64'd1);
            end
        end
        if (!got) begin
            chk("whilo_wait_expired", 64'd0, 64'd1);
            ex_stall_i = 1'b0;
            tick();
            return;
        end
        chk("latency", 64'(n), 64'(lat + 1));
        chk("done_stallreq", 64'(stallreq_o), 64'd0);
        chk("done_start", 64'(div_start_o), 64'd0);
        nw = 1;
        for (int j = 0; j < hold; j++) begin
            tick();
            if (j == hold - 1) ex_stall_i = 1'b0;
            @(negedge clk);
            if (whilo_o) nw++;
        end
        chk("whilo_cycles", 64'(nw), 64'(hold + 1));
        tick();
        @(negedge clk);
        chk("back_idle_whilo", 64'(whilo_o), 64'd0);
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          na;
        int          ns;
        bit          got;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_start", 64'(div_start_o), 64'd0);
        chk("rst_annul", 64'(div_annul_o), 64'd0);
        chk("rst_signed", 64'(signed_div_o), 64'd0);
        chk("rst_op1", 64'(div_opdata1_o), 64'd0);
        chk("rst_op2", 64'(div_opdata2_o), 64'd0);
        chk("rst_stallreq", 64'(stallreq_o), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_whilo", 64'(whilo_o), 64'd0);
        chk("rst_div0", 64'(div0_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        run_div(C_DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 3, 0);
        run_div(C_DIV_OP_DIVU, 32'd100, 32'd7, 5, 0);
        run_div(C_DIV_OP_DIV, 32'd123, 32'd0, 4, 0);
        run_div(C_DIV_OP_DIVU, 32'hDEAD_BEEF, 32'd16, 2, 4);

        // Flush on the third WAIT cycle.
        div_lat = 50;
        div_op_i = C_DIV_OP_DIV; reg1_i = 32'd77; reg2_i = 32'd5; ex_stall_i = 1'b0;
        tick();
        div_op_i = 2'b00;
        tick();
        tick();
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_annul", 64'(div_annul_o), 64'd1);
        chk("flush_start", 64'(div_start_o), 64'd0);
        na = 1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (div_annul_o) na++;
            if (div_start_o) na += 100;
            tick();
        end
        chk("flush_annul_cycles", 64'(na), 64'd1);
        run_div(C_DIV_OP_DIVU, 32'd9, 32'd3, 3, 0);

        // Flush coinciding with an issue: nothing starts.
        div_op_i = C_DIV_OP_DIVU; reg1_i = 32'd40; reg2_i = 32'd4; flush_i = 1'b1;
        @(negedge clk);
        chk("flush_issue_stallreq", 64'(stallreq_o), 64'd0);
        tick();
        div_op_i = 2'b00; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_issue_start", 64'(div_start_o), 64'd0);
        tick();

        // Flush while held in DONE.
        push_exp(C_DIV_OP_DIV, 32'd50, 32'd6);
        div_lat = 2;
        div_op_i = C_DIV_OP_DIV; reg1_i = 32'd50; reg2_i = 32'd6; ex_stall_i = 1'b1;
        tick();
        div_op_i = 2'b00;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (whilo_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_flush_reached", 64'(got), 64'd1);
        tick();
        flush_i = 1'b1;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        @(negedge clk);
        chk("done_flush_whilo", 64'(whilo_o), 64'd0);
        tick();
        flush_i = 1'b0; ex_stall_i = 1'b0;
        @(negedge clk);
        chk("done_flush_idle", 64'(whilo_o), 64'd0);
        tick();

        // Reset mid-WAIT: start drops with no annul.
        div_lat = 50;
        div_op_i = C_DIV_OP_DIVU; reg1_i = 32'd8; reg2_i = 32'd2;
        tick();
        div_op_i = 2'b00;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_start_pre", 64'(div_start_o), 64'd1);
        tick();
        @(negedge clk);
        chk("rst_wait_start", 64'(div_start_o), 64'd0);
        chk("rst_wait_annul", 64'(div_annul_o), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_annul_post", 64'(div_annul_o), 64'd0);
        tick();

        for (int k = 0; k < 40; k++) begin
            op = ($urandom_range(0, 1) == 1) ? C_DIV_OP_DIV : C_DIV_OP_DIVU;
            case ($urandom_range(0, 2))
                0:       a = $urandom;
                1:       a = $urandom_range(0, 1000);
                default: a = -$urandom_range(1, 1000);
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom;
                3:       b = -$urandom_range(1, 50);
                default: b = $urandom_range(1, 50);
            endcase
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            run_div(op, a, b, $urandom_range(1, 8), $urandom_range(0, 3));
        end

        // Divider never answers: timeout.
        div_respond = 1'b0;
        div_op_i = C_DIV_OP_DIV; reg1_i = 32'd50; reg2_i = 32'd5;
        tick();
        div_op_i = 2'b00;
        ns = 0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (div_start_o) ns++;
            if (div_annul_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("timeout_fired", 64'(got), 64'd1);
        chk("timeout_wait_cycles", 64'(ns), 64'd64);
        chk("timeout_sticky_set", 64'(timeout_o), 64'd1);
        chk("timeout_no_whilo", 64'(whilo_o), 64'd0);
        tick();
        @(negedge clk);
        chk("timeout_annul_single", 64'(div_annul_o), 64'd0);
        tick();
        run_div(C_DIV_OP_DIVU, 32'd20, 32'd6, 3, 0);
        @(negedge clk);
        chk("timeout_still_set", 64'(timeout_o), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("timeout_cleared", 64'(timeout_o), 64'd0);
        tick();

        repeat (3) tick();
        chk("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_div_ctrl
`default_nettype wire
